// File: rtl/crc_host_driver.sv
// rtl/crc_host_driver.sv - streams message bytes into a CRC32C peripheral over a strobed register bus
module crc_host_driver #(
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES    = 4,
    parameter int POLL_LIMIT    = 4096,
    parameter int MAX_BYTES     = 250
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] saddress,
    output logic        swr,
    output logic        srd,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] result
);
    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam logic [15:0] A_IN     = 16'h0640;
    localparam logic [15:0] A_STATUS = 16'h0648;
    localparam logic [15:0] A_RESULT = 16'h0650;
    localparam logic [15:0] A_CTRL   = 16'h0658;

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_WAIT_BYTE, S_IN_WR, S_PUT_WR,
        S_GET_WR, S_POLL, S_RES_RD, S_DONE, S_ERR
    } state_t;
    typedef enum logic [1:0] {P_SETUP, P_STROBE, P_HOLD, P_GAP} phase_t;

    state_t         state;
    phase_t         phase;
    logic [15:0]    cnt;
    logic [7:0]     byte_cnt;
    logic [PW-1:0]  poll_cnt;
    logic           last_q;
    logic           abort;

    logic in_access, is_read, gap_needed, acc_end;

    // acc_end marks the last cycle of an access, including any CTRL gap
    always_comb begin
        in_access  = state inside {S_CLR, S_IN_WR, S_PUT_WR, S_GET_WR, S_POLL, S_RES_RD};
        is_read    = state inside {S_POLL, S_RES_RD};
        gap_needed = (GAP_CYCLES > 0) && (state inside {S_CLR, S_PUT_WR, S_GET_WR});
        acc_end    = in_access && ((phase == P_HOLD && !gap_needed) ||
                                   (phase == P_GAP && cnt == 16'd0));
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= S_IDLE;
            phase     <= P_SETUP;
            cnt       <= 16'd0;
            byte_cnt  <= 8'd0;
            poll_cnt  <= '0;
            last_q    <= 1'b0;
            abort     <= 1'b0;
            in_ready  <= 1'b0;
            saddress  <= 16'd0;
            swr       <= 1'b0;
            srd       <= 1'b0;
            sdata_out <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            result    <= 32'd0;
        end else begin
            if (in_access) begin
                case (phase)
                    P_SETUP: begin
                        phase <= P_STROBE;
                        cnt   <= 16'(STROBE_CYCLES - 1);
                        if (is_read) srd <= 1'b1;
                        else         swr <= 1'b1;
                    end
                    P_STROBE: begin
                        if (cnt == 16'd0) begin
                            srd   <= 1'b0;
                            swr   <= 1'b0;
                            phase <= P_HOLD;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                    P_HOLD: begin
                        if (gap_needed) begin
                            phase <= P_GAP;
                            cnt   <= 16'(GAP_CYCLES - 1);
                        end
                    end
                    P_GAP: begin
                        if (cnt != 16'd0) cnt <= cnt - 16'd1;
                    end
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_CLR;
                        busy      <= 1'b1;
                        byte_cnt  <= 8'd0;
                        abort     <= 1'b0;
                        saddress  <= A_CTRL;
                        sdata_out <= 32'd3;
                        phase     <= P_SETUP;
                    end
                end
                S_WAIT_BYTE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (byte_cnt == 8'(MAX_BYTES)) begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end else begin
                            last_q    <= in_last;
                            state     <= S_IN_WR;
                            saddress  <= A_IN;
                            sdata_out <= {24'd0, in_data};
                            phase     <= P_SETUP;
                        end
                    end
                end
                S_CLR: begin
                    if (acc_end) begin
                        if (abort) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            abort <= 1'b0;
                        end else begin
                            state    <= S_WAIT_BYTE;
                            in_ready <= 1'b1;
                        end
                    end
                end
                S_IN_WR: begin
                    if (acc_end) begin
                        state     <= S_PUT_WR;
                        saddress  <= A_CTRL;
                        sdata_out <= 32'd1;
                        phase     <= P_SETUP;
                    end
                end
                S_PUT_WR: begin
                    if (acc_end) begin
                        byte_cnt <= byte_cnt + 8'd1;
                        if (last_q) begin
                            state     <= S_GET_WR;
                            saddress  <= A_CTRL;
                            sdata_out <= 32'd2;
                            phase     <= P_SETUP;
                        end else begin
                            state    <= S_WAIT_BYTE;
                            in_ready <= 1'b1;
                        end
                    end
                end
                S_GET_WR: begin
                    if (acc_end) begin
                        state     <= S_POLL;
                        saddress  <= A_STATUS;
                        sdata_out <= 32'd0;
                        poll_cnt  <= '0;
                        phase     <= P_SETUP;
                    end
                end
                S_POLL: begin
                    if (acc_end) begin
                        poll_cnt <= poll_cnt + PW'(1);
                        if (sdata_in[1:0] == 2'd3) begin
                            state    <= S_RES_RD;
                            saddress <= A_RESULT;
                            phase    <= P_SETUP;
                        end else if (poll_cnt + PW'(1) == PW'(POLL_LIMIT)) begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end else begin
                            phase <= P_SETUP;
                        end
                    end
                end
                S_RES_RD: begin
                    if (acc_end) begin
                        result <= sdata_in;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_ERR: begin
                    // leave the peripheral cleared before going idle
                    error     <= 1'b0;
                    abort     <= 1'b1;
                    state     <= S_CLR;
                    saddress  <= A_CTRL;
                    sdata_out <= 32'd3;
                    phase     <= P_SETUP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
